// File: rtl/smem_responder_if.sv
// Request/response bundle for the search-image memory responder.
// The requester (SAD datapath, image loader) takes the master side.
interface smem_responder_if #(
  parameter int PortNum = 4,
  parameter int AW      = 10
);
  logic                          req_valid;
  logic                          req_write;
  logic [AW-1:0]                 req_waddr;
  logic [7:0]                    req_wdata;
  logic [PortNum-1:0][AW-1:0]    req_raddr;
  logic                          ready;
  logic [PortNum-1:0][7:0]       res_data;
  logic                          res_valid;
  logic [PortNum-1:0]            oob;
  logic                          wr_err;

  modport master (
    output req_valid, req_write, req_waddr, req_wdata, req_raddr,
    input  ready, res_data, res_valid, oob, wr_err
  );

  modport slave (
    input  req_valid, req_write, req_waddr, req_wdata, req_raddr,
    output ready, res_data, res_valid, oob, wr_err
  );
endinterface

// File: rtl/smem_responder.sv
// Search-image memory responder: SImgSize x SImgSize bytes, one write and
// PortNum reads per cycle, read data registered one cycle after accept.
// Memory is swept to zero after every reset before requests are accepted.
// Optional macro SMEM_BYPASS_EN: same-cycle write data forwards to matching
// read ports (write-first); otherwise reads see the pre-write contents.

// One read lane: registers the selected byte and its out-of-bounds flag.
module smem_rd_lane (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       acc,
  input  logic       miss,
  input  logic [7:0] rdata,
  input  logic       fwd,
  input  logic [7:0] wdata,
  output logic [7:0] data,
  output logic       oob
);
  // Data holds between accepts; oob is a per-response flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data <= '0;
      oob  <= 1'b0;
    end else begin
      oob <= acc && miss;
      if (acc) data <= fwd ? wdata : rdata;
    end
  end
endmodule

module smem_responder #(
  parameter int SImgSize = 31,
  parameter int PortNum  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  smem_responder_if.slave  bus
);
  localparam int Depth   = SImgSize * SImgSize;
  localparam int AW      = $clog2(Depth);
  localparam int LastIdx = Depth - 1;
  localparam logic [AW:0]   DepthC = Depth[AW:0];
  localparam logic [AW-1:0] LastC  = LastIdx[AW-1:0];

  typedef enum logic {CLEAR, READY} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_we;
  logic          ready_c;
  logic          acc;
  logic          waddr_in;
  logic          wr_ok;
  logic          res_valid_q;
  logic          wr_err_q;

  logic [7:0]    mem [Depth];

  // State and clear-counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep every location once, then serve requests until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    ready_c = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastC) state_d = READY;
      end
      READY: ready_c = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  assign acc      = bus.req_valid && ready_c;
  assign waddr_in = {1'b0, bus.req_waddr} < DepthC;
  assign wr_ok    = acc && bus.req_write && waddr_in;

  // Storage: clear sweep has priority; requests cannot arrive while clearing.
  always_ff @(posedge clk_i) begin
    if (clr_we)     mem[cnt_q]         <= '0;
    else if (wr_ok) mem[bus.req_waddr] <= bus.req_wdata;
  end

  // Response qualifier and dropped-write pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      res_valid_q <= acc;
      wr_err_q    <= acc && bus.req_write && !waddr_in;
    end
  end

  for (genvar p = 0; p < PortNum; p++) begin : g_port
    logic       inb;
    logic [7:0] rdat;
    logic       fwd;

    // Out-of-range addresses read as zero and never index the array.
    assign inb  = {1'b0, bus.req_raddr[p]} < DepthC;
    assign rdat = inb ? mem[bus.req_raddr[p]] : 8'h00;
`ifdef SMEM_BYPASS_EN
    assign fwd  = wr_ok && (bus.req_waddr == bus.req_raddr[p]);
`else
    assign fwd  = 1'b0;
`endif

    smem_rd_lane u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .acc    (acc),
      .miss   (!inb),
      .rdata  (rdat),
      .fwd    (fwd),
      .wdata  (bus.req_wdata),
      .data   (bus.res_data[p]),
      .oob    (bus.oob[p])
    );
  end

  assign bus.ready     = ready_c;
  assign bus.res_valid = res_valid_q;
  assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_smem_responder.sv
// Randomized + directed bench for smem_responder against a byte-array model.
module tb_smem_responder;
  localparam int PN    = 4;
  localparam int AW    = 10;
  localparam int DEPTH = 961;
`ifdef SMEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  smem_responder_if #(.PortNum(PN), .AW(AW)) bus ();

  smem_responder #(.SImgSize(31), .PortNum(PN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0]  ref_mem [1024];
  logic [31:0] exp_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PN-1:0][AW-1:0] mk(input int a0, input int a1, input int a2, input int a3);
    logic [PN-1:0][AW-1:0] r;
    r[0] = a0[AW-1:0]; r[1] = a1[AW-1:0]; r[2] = a2[AW-1:0]; r[3] = a3[AW-1:0];
    return r;
  endfunction

  // One request cycle; model predicts the response from its own array.
  task automatic op(input bit v, input bit w, input int wa, input logic [7:0] wd,
                    input logic [PN-1:0][AW-1:0] ra);
    logic [PN-1:0] eoob;
    logic [31:0]   nd;
    bit            eerr;
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_waddr = wa[AW-1:0];
    bus.req_wdata = wd;
    bus.req_raddr = ra;
    eoob = '0; nd = exp_data; eerr = 1'b0;
    if (v) begin
      for (int p = 0; p < PN; p++) begin
        if (int'(ra[p]) >= DEPTH) begin
          eoob[p] = 1'b1;
          nd[p*8 +: 8] = 8'h00;
        end else if (BYP && w && wa < DEPTH && wa == int'(ra[p])) begin
          nd[p*8 +: 8] = wd;
        end else begin
          nd[p*8 +: 8] = ref_mem[ra[p]];
        end
      end
      if (w) begin
        if (wa < DEPTH) ref_mem[wa] = wd;
        else eerr = 1'b1;
      end
    end
    exp_data = nd;
    @(posedge clk); #1;
    chk("res_valid", bus.res_valid, v);
    chk("oob", bus.oob, eoob);
    chk("data", bus.res_data, exp_data);
    chk("wr_err", bus.wr_err, eerr);
  endtask

  // Hold requests active through the sweep and measure its length.
  task automatic wait_clear();
    int n;
    bit rv;
    n = 0; rv = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_waddr = '0;
    bus.req_wdata = 8'hFF;
    while (bus.ready !== 1'b1 && n < 2000) begin
      bus.req_raddr = mk($urandom_range(0, 960), 480, 960, 0);
      @(posedge clk); #1;
      n++;
      if (bus.res_valid !== 1'b0) rv = 1'b1;
    end
    chk("clr_len", n, 961);
    chk("clr_rv", rv, 0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    exp_data = '0;
  endtask

  initial begin
    int cnt;
    int wa;
    logic [PN-1:0][AW-1:0] ra;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_waddr = '0;
    bus.req_wdata = '0;
    bus.req_raddr = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    #12;
    chk("rst_ready", bus.ready, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_data", bus.res_data, 0);
    chk("rst_oob", bus.oob, 0);
    chk("rst_wrerr", bus.wr_err, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_clear();

    op(1, 0, 0, 8'h00, mk(0, 480, 960, 0));
    chk("clr_zero", bus.res_data, 32'h0);

    op(1, 1, 0,   8'hA5, mk(0, 0, 0, 0));
    op(1, 1, 30,  8'h3C, mk(0, 0, 0, 0));
    op(1, 1, 930, 8'h7F, mk(0, 0, 0, 0));
    op(1, 1, 960, 8'hFF, mk(0, 0, 0, 0));
    op(1, 0, 0, 8'h00, mk(0, 30, 930, 960));
    chk("dir_rd", bus.res_data, 32'hFF7F3CA5);
    chk("dir_oob", bus.oob, 4'b0000);

    op(1, 0, 0, 8'h00, mk(961, 1023, 5, 961));
    chk("oob_vec", bus.oob, 4'b1011);
    op(1, 1, 1000, 8'h55, mk(39, 0, 5, 5));
    chk("wr_err_pulse", bus.wr_err, 1);
    op(0, 0, 0, 8'h00, mk(0, 0, 0, 0));
    chk("wr_err_end", bus.wr_err, 0);
    op(1, 0, 0, 8'h00, mk(39, 0, 1000, 960));

    op(1, 1, 100, 8'h11, mk(0, 0, 0, 0));
    op(1, 1, 100, 8'h22, mk(0, 0, 100, 0));
    chk("rbw_same", bus.res_data[2], BYP ? 8'h22 : 8'h11);
    op(1, 0, 0, 8'h00, mk(100, 0, 0, 0));
    chk("rbw_after", bus.res_data[0], 8'h22);

    for (int i = 0; i < 16; i++) op(1, 1, 200 + i, 8'(8'h40 + i), mk(0, 0, 0, 0));
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      op(1, 0, 0, 8'h00, mk(200 + i, 201 + i, 100, 200 + i));
      if (bus.res_valid === 1'b1 && bus.res_data[0] === 8'(8'h40 + i)) cnt++;
    end
    chk("b2b_cnt", cnt, 16);
    op(0, 0, 0, 8'h00, mk(0, 0, 0, 0));
    chk("gap", bus.res_valid, 0);
    op(1, 0, 0, 8'h00, mk(215, 0, 0, 0));
    chk("gap_end", bus.res_valid, 1);

    for (int i = 0; i < 400; i++) begin
      wa = ($urandom_range(0, 7) == 0) ? 961 + $urandom_range(0, 62) : $urandom_range(0, 63);
      for (int p = 0; p < PN; p++) begin
        case ($urandom_range(0, 7))
          0:       ra[p] = 10'(961 + $urandom_range(0, 62));
          1, 2:    ra[p] = 10'(wa);
          3:       ra[p] = 10'($urandom_range(0, 960));
          default: ra[p] = 10'($urandom_range(0, 63));
        endcase
      end
      op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, wa, 8'($urandom), ra);
    end

    op(1, 1, 300, 8'h77, mk(0, 0, 0, 0));
    op(1, 0, 0, 8'h00, mk(300, 300, 300, 300));
    chk("pre_rst_valid", bus.res_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.res_valid, 0);
    chk("mid_rst_data", bus.res_data, 32'h0);
    chk("mid_rst_ready", bus.ready, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_clear();
    op(1, 0, 0, 8'h00, mk(300, 100, 0, 960));
    chk("post_rst_zero", bus.res_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
